// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB types, bus-segment constants and slave address map.
package ahb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;
    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_e;
    localparam int AHB_NUM_MASTERS    = 4;
    localparam int AHB_DEFAULT_MASTER = 0;
    localparam logic [31:0] SLV_MASK  = 32'hF000_0000;
    localparam logic [31:0] SLV0_BASE = 32'h0000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h1000_0000;
    localparam logic [31:0] SLV2_BASE = 32'h2000_0000;
    localparam logic [31:0] SLV3_BASE = 32'h4000_0000;
    // Beats in a burst; 0 marks undefined-length INCR.
    function automatic logic [4:0] burst_len(input hburst_e hburst);
        return hburst[2:1] == 2'b01 ? 5'd4 :
               hburst[2:1] == 2'b10 ? 5'd8 :
               hburst[2:1] == 2'b11 ? 5'd16 :
               hburst[0] ? 5'd0 : 5'd1;
    endfunction
endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: combinational round-robin picker; searches req_i starting one past ptr_i.
module ahb_rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);
    logic [PW:0] pos;
    logic        found;
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 1; i <= N; i++) begin
            pos = {1'b0, ptr_i} + (PW+1)'(i);
            pos = pos >= (PW+1)'(N) ? pos - (PW+1)'(N) : pos;
            if (!found && req_i[pos[PW-1:0]]) begin
                gnt_o[pos[PW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end
    assign valid_o = |req_i;
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter with burst/lock/wait-state aware re-arbitration
// and registered HMASTER/HMASTLOCK that trail the grant by one completed transfer.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = AHB_NUM_MASTERS,
    parameter int DEFAULT_MASTER = AHB_DEFAULT_MASTER,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] grant_q, grant_d, pick;
    logic [MW-1:0]          master_q, master_d, rr_q, rr_d, gnt_idx, pick_idx;
    logic                   mlock_q, mlock_d, pick_valid, lock_hold, rearb;
    logic [3:0]             cnt_q, cnt_d, nonseq_load;
    logic [4:0]             len;

    ahb_rr_picker #(.N(NUM_MASTERS), .PW(MW)) u_picker (
        .req_i  (HBUSREQ),
        .ptr_i  (rr_q),
        .gnt_o  (pick),
        .valid_o(pick_valid)
    );

    always_comb begin
        gnt_idx  = '0;
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            gnt_idx  = grant_q[i] ? MW'(i) : gnt_idx;
            pick_idx = pick[i] ? MW'(i) : pick_idx;
        end
    end

    // Counter holds the beats still to come after the current address phase.
    assign len         = burst_len(hburst_e'(HBURST));
    assign nonseq_load = len > 5'd1 ? 4'(len - 5'd1) : 4'd0;
    assign cnt_d = !HREADY          ? cnt_q :
                   HTRANS == NONSEQ ? nonseq_load :
                   HTRANS == SEQ    ? (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q) :
                   HTRANS == IDLE   ? 4'd0 : cnt_q;

    assign lock_hold = HLOCK[gnt_idx];
    assign rearb     = HREADY && !lock_hold && cnt_d == 4'd0 && HTRANS != BUSY;
    assign grant_d   = rearb ? (pick_valid ? pick : DEF_GNT) : grant_q;
    assign rr_d      = rearb && pick_valid ? pick_idx : rr_q;
    assign master_d  = HREADY ? gnt_idx : master_q;
    assign mlock_d   = HREADY ? HLOCK[gnt_idx] : mlock_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q  <= DEF_GNT;
            master_q <= DEF_IDX;
            mlock_q  <= 1'b0;
            cnt_q    <= 4'd0;
            rr_q     <= DEF_IDX;
        end else begin
            grant_q  <= grant_d;
            master_q <= master_d;
            mlock_q  <= mlock_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenario tests for ahb_arbiter with hand-computed expectations.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic [3:0] HBUSREQ = '0;
    logic [3:0] HLOCK = '0;
    logic [1:0] HTRANS = IDLE;
    logic [2:0] HBURST = SINGLE;
    logic       HREADY = 1'b1;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;
    int passed = 0;
    int total  = 0;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_reset;
        HRESETn = 1'b0;
        HBUSREQ = '0;
        HLOCK   = '0;
        HTRANS  = IDLE;
        HBURST  = SINGLE;
        HREADY  = 1'b1;
        tick;
        HRESETn = 1'b1;
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        HBUSREQ = 4'b1111;
        HLOCK   = '0;
        HTRANS  = NONSEQ;
        HBURST  = SINGLE;
        HREADY  = 1'b1;
        tick;
        tick;
        total++; if (HGRANT !== 4'b0001) $display("FAIL reset_grant: got %b expected %b", HGRANT, 4'b0001); else passed++;
        total++; if (HMASTER !== 2'd0) $display("FAIL reset_master: got %0d expected 0", HMASTER); else passed++;
        total++; if (HMASTLOCK !== 1'b0) $display("FAIL reset_mastlock: got %b expected 0", HMASTLOCK); else passed++;
        HRESETn = 1'b1;
        #3;
        total++; if (HGRANT !== 4'b0001) $display("FAIL reset_release_hold: got %b expected %b", HGRANT, 4'b0001); else passed++;
        tick;
        total++; if (HGRANT !== 4'b0010) $display("FAIL reset_first_edge: got %b expected %b", HGRANT, 4'b0010); else passed++;
        tick;
        total++; if (HMASTER !== 2'd1) $display("FAIL reset_pre_async_master: got %0d expected 1", HMASTER); else passed++;
        HRESETn = 1'b0;
        #1;
        total++; if (HGRANT !== 4'b0001) $display("FAIL reset_async_grant: got %b expected %b", HGRANT, 4'b0001); else passed++;
        total++; if (HMASTER !== 2'd0) $display("FAIL reset_async_master: got %0d expected 0", HMASTER); else passed++;
    endtask

    task automatic test_round_robin;
        logic [3:0] eg;
        logic [1:0] em;
        apply_reset;
        HBUSREQ = 4'b1111;
        HTRANS  = NONSEQ;
        HBURST  = SINGLE;
        for (int k = 1; k <= 8; k++) begin
            tick;
            eg = 4'b0001 << (k % 4);
            em = 2'((k - 1) % 4);
            total++; if (HGRANT !== eg) $display("FAIL rr_grant[%0d]: got %b expected %b", k, HGRANT, eg); else passed++;
            total++; if (HMASTER !== em) $display("FAIL rr_master[%0d]: got %0d expected %0d", k, HMASTER, em); else passed++;
        end
    endtask

    task automatic test_fixed_burst;
        logic [1:0] tra [4] = '{NONSEQ, SEQ, SEQ, SEQ};
        logic [3:0] ega [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic [1:0] trb [6] = '{NONSEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
        logic       rdb [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] egb [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        apply_reset;
        HBUSREQ = 4'b0010;
        tick;
        total++; if (HGRANT !== 4'b0010) $display("FAIL burst_setup_grant: got %b expected %b", HGRANT, 4'b0010); else passed++;
        tick;
        total++; if (HGRANT !== 4'b0010 || HMASTER !== 2'd1) $display("FAIL burst_sole_owner: got %b/%0d expected 0010/1", HGRANT, HMASTER); else passed++;
        HBUSREQ = 4'b0110;
        HBURST  = INCR4;
        for (int i = 0; i < 4; i++) begin
            HTRANS = tra[i];
            tick;
            total++; if (HGRANT !== ega[i]) $display("FAIL incr4_grant[%0d]: got %b expected %b", i, HGRANT, ega[i]); else passed++;
        end
        apply_reset;
        HBUSREQ = 4'b0010;
        tick;
        tick;
        HBUSREQ = 4'b0110;
        HBURST  = INCR4;
        for (int i = 0; i < 6; i++) begin
            HTRANS = trb[i];
            HREADY = rdb[i];
            tick;
            total++; if (HGRANT !== egb[i]) $display("FAIL incr4_wait_grant[%0d]: got %b expected %b", i, HGRANT, egb[i]); else passed++;
            total++; if (HMASTER !== 2'd1) $display("FAIL incr4_wait_master[%0d]: got %0d expected 1", i, HMASTER); else passed++;
        end
        HREADY = 1'b1;
    endtask

    task automatic test_lock;
        apply_reset;
        HBUSREQ = 4'b1000;
        HLOCK   = 4'b1000;
        tick;
        total++; if (HGRANT !== 4'b1000) $display("FAIL lock_grant_m3: got %b expected %b", HGRANT, 4'b1000); else passed++;
        tick;
        total++; if (HMASTER !== 2'd3 || HMASTLOCK !== 1'b1) $display("FAIL lock_owner: got %0d/%b expected 3/1", HMASTER, HMASTLOCK); else passed++;
        HBUSREQ = 4'b1111;
        HTRANS  = NONSEQ;
        HBURST  = SINGLE;
        for (int i = 0; i < 5; i++) begin
            tick;
            total++; if (HGRANT !== 4'b1000) $display("FAIL lock_hold_grant[%0d]: got %b expected %b", i, HGRANT, 4'b1000); else passed++;
            total++; if (HMASTLOCK !== 1'b1) $display("FAIL lock_hold_mastlock[%0d]: got %b expected 1", i, HMASTLOCK); else passed++;
        end
        HLOCK  = 4'b0000;
        HREADY = 1'b0;
        tick;
        total++; if (HGRANT !== 4'b1000 || HMASTLOCK !== 1'b1) $display("FAIL lock_drop_wait: got %b/%b expected 1000/1", HGRANT, HMASTLOCK); else passed++;
        HREADY = 1'b1;
        tick;
        total++; if (HGRANT !== 4'b0001) $display("FAIL lock_release_grant: got %b expected %b", HGRANT, 4'b0001); else passed++;
        total++; if (HMASTLOCK !== 1'b0 || HMASTER !== 2'd3) $display("FAIL lock_release_owner: got %0d/%b expected 3/0", HMASTER, HMASTLOCK); else passed++;
    endtask

    task automatic test_busy_incr8;
        logic [1:0] tr [10] = '{NONSEQ, SEQ, SEQ, BUSY, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ};
        logic [3:0] eg;
        apply_reset;
        HBUSREQ = 4'b0010;
        tick;
        tick;
        HBUSREQ = 4'b0101;
        HBURST  = INCR8;
        for (int i = 0; i < 10; i++) begin
            HTRANS = tr[i];
            tick;
            eg = (i == 9) ? 4'b0100 : 4'b0010;
            total++; if (HGRANT !== eg) $display("FAIL incr8_busy_grant[%0d]: got %b expected %b", i, HGRANT, eg); else passed++;
        end
    endtask

    task automatic test_idle;
        apply_reset;
        HBUSREQ = 4'b0010;
        tick;
        total++; if (HGRANT !== 4'b0010) $display("FAIL idle_setup_grant: got %b expected %b", HGRANT, 4'b0010); else passed++;
        HBUSREQ = 4'b0000;
        HLOCK   = 4'b0100;
        tick;
        total++; if (HGRANT !== 4'b0001) $display("FAIL idle_default_grant: got %b expected %b", HGRANT, 4'b0001); else passed++;
        tick;
        total++; if (HGRANT !== 4'b0001 || HMASTER !== 2'd0) $display("FAIL idle_default_hold: got %b/%0d expected 0001/0", HGRANT, HMASTER); else passed++;
        HLOCK   = 4'b0000;
        HBUSREQ = 4'b0011;
        tick;
        total++; if (HGRANT !== 4'b0001) $display("FAIL idle_rr_kept: got %b expected %b", HGRANT, 4'b0001); else passed++;
        HBUSREQ = 4'b0100;
        tick;
        total++; if (HGRANT !== 4'b0100) $display("FAIL idle_single_req: got %b expected %b", HGRANT, 4'b0100); else passed++;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_fixed_burst;
        test_lock;
        test_busy_incr8;
        test_idle;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
